// File: rtl/taillight_sequencer.sv
// -----------------------------------------------------------------------------
// taillight_sequencer
//
// Rear-lamp sequencer with LAMPS lamps per side. A turn request fills one side
// from the innermost lamp outwards, one lamp per step, then shows a dark step
// and starts again. Hazard flashes both sides together. Brake forces every side
// that is not showing a turn fill to all-on. A step lasts DWELL Enable-high
// cycles.
//
// Parameters
//   LAMPS  lamps per side (2..8)
//   DWELL  Enable-high cycles per sequence step (1..256)
//
// Ports
//   Clock       system clock, rising edge
//   Reset_n     asynchronous active-low reset
//   Enable      step tick; only Enable-high cycles count toward the dwell
//   L, R, H     left / right / hazard requests, sampled only on an advance
//   B           brake request, combinational overlay on the outputs
//   LeftOut     left lamps, bit 0 innermost
//   RightOut    right lamps, bit 0 innermost
//   Busy        high whenever the sequencer is not idle
//   DebugState  current sequencer state (IDLE=0, LSEQ=1, RSEQ=2, HAZ=3)
//
// Handshake: there is no valid/ready pair. Enable is a qualifier, not a
// request: the block never stalls it and never acknowledges it; a cycle with
// Enable low is simply invisible to the state and the dwell counter.
// -----------------------------------------------------------------------------
module taillight_sequencer #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DWELL = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             L,
  input  logic             R,
  input  logic             H,
  input  logic             B,
  output logic [LAMPS-1:0] LeftOut,
  output logic [LAMPS-1:0] RightOut,
  output logic             Busy,
  output logic [1:0]       DebugState
);

  // Dwell counter is at least one bit wide even when DWELL is 1.
  localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Step index holds 1..LAMPS.
  localparam int unsigned KW  = $clog2(LAMPS + 1);

  localparam logic [DCW-1:0] DC_LAST = DCW'(DWELL - 1);
  localparam logic [KW-1:0]  K_FIRST = KW'(1);
  localparam logic [KW-1:0]  K_LAST  = KW'(LAMPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LSEQ = 2'd1,
    RSEQ = 2'd2,
    HAZ  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [KW-1:0]  k, k_nxt;
  logic [DCW-1:0] dc;
  logic           advance;
  logic [LAMPS-1:0] fill_pat;

  assign advance = Enable && (dc == DC_LAST);

  // ---------------------------------------------------------------------------
  // State register. Everything is held while Enable is low; next-state logic
  // already returns the current state on non-advancing cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      k     <= K_FIRST;
      dc    <= '0;
    end else if (Enable) begin
      dc    <= advance ? '0 : dc + DCW'(1);
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. Requests only matter on an advance. Any exit to IDLE reloads
  // K so a fresh sequence always starts from the innermost lamp.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (advance) begin
      unique case (state)
        IDLE: begin
          if (H) begin
            state_nxt = HAZ;
          end else if (L && !R) begin
            state_nxt = LSEQ;
            k_nxt     = K_FIRST;
          end else if (!L && R) begin
            state_nxt = RSEQ;
            k_nxt     = K_FIRST;
          end
        end
        LSEQ: begin
          if (H || !(L && !R) || (k == K_LAST)) begin
            // abort, or the dark step after a full fill
            state_nxt = IDLE;
            k_nxt     = K_FIRST;
          end else begin
            k_nxt = k + KW'(1);
          end
        end
        RSEQ: begin
          if (H || !(!L && R) || (k == K_LAST)) begin
            state_nxt = IDLE;
            k_nxt     = K_FIRST;
          end else begin
            k_nxt = k + KW'(1);
          end
        end
        HAZ: begin
          state_nxt = IDLE;
          k_nxt     = K_FIRST;
        end
        default: begin
          state_nxt = IDLE;
          k_nxt     = K_FIRST;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. The fill pattern has the K innermost bits set. Brake is a
  // pure combinational overlay so it shows in the same cycle as B.
  // ---------------------------------------------------------------------------
  always_comb begin
    fill_pat = '0;
    for (int i = 0; i < int'(LAMPS); i++) begin
      fill_pat[i] = (KW'(i) < k);
    end
  end

  always_comb begin
    LeftOut  = '0;
    RightOut = '0;
    unique case (state)
      LSEQ:    LeftOut  = fill_pat;
      RSEQ:    RightOut = fill_pat;
      HAZ: begin
        LeftOut  = '1;
        RightOut = '1;
      end
      default: ;
    endcase
    if (B) begin
      if (state != LSEQ) LeftOut  = '1;
      if (state != RSEQ) RightOut = '1;
    end
  end

  assign Busy       = (state != IDLE);
  assign DebugState = state;

endmodule
